// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin arbiter plus APB master sharing one APB bus
// among NUM_REQ local requesters, one single-beat transfer in flight.
// Ports: clk, reset_n (async, active-low); req_valid/req_write/req_addr/
//   req_wdata in, req_ready out (per requester, packed);
//   rsp_valid/rsp_rdata/rsp_err out (completion);
//   psel/penable/pwrite/paddr/pwdata out, prdata/pready in (APB).
// Option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
//   cycles without pready (completion with rsp_err=1).
module apb_rr_master #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [ADDR_WIDTH-1:0]          paddr,
    output logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH-1:0]          prdata,
    input  logic                           pready
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_rr_master: NUM_REQ must be >= 2, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    // ptr_q doubles as the index of the requester owning the bus
    logic [IW-1:0]           ptr_q, ptr_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    gnt_any;
    logic [IW-1:0]           gnt_idx;
    logic                    expire;

    // Round-robin search starting just after the last winner
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_err_q, rsp_err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expires on the TIMEOUT_CYCLES-th ACCESS cycle with pready low
    assign expire = (state_q == ACCESS) && !pready &&
                    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = '0;
`ifdef APB_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    // Accept strobe is suppressed while reset is held
                    req_ready[gnt_idx] = reset_n;
                    ptr_d    = gnt_idx;
                    pwrite_d = req_write[gnt_idx];
                    paddr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_d = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_valid_d[ptr_q] = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = IDLE;
                end else if (expire) begin
                    rsp_valid_d[ptr_q] = 1'b1;
                    rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
                    rsp_err_d   = 1'b1;
`endif
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(NUM_REQ - 1);
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign psel      = (state_q != IDLE);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: self-checking bench for apb_rr_master
// with a transaction-level arbitration and completion model.
module tb_apb_rr_master;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;

    apb_rr_master #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: last winner, and the completion owed next cycle
    int          ptr_m;
    bit          rsp_pend;
    int          rsp_g;
    logic [DW-1:0] rsp_data;

    function automatic int ref_grant(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    // Called at a falling edge with requests already driven.
    // Runs accept, SETUP, ACCESS (waits stalls), returns at the
    // falling edge of the completion cycle.
    task automatic xfer(input int waits, input logic [DW-1:0] rd,
                        input bit keep);
        int g;
        logic [N-1:0] exp_rdy;
        logic w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        #1;
        if (rsp_pend) begin
            n_chk++;
            if (rsp_valid !== N'(1 << rsp_g) || rsp_rdata !== rsp_data ||
                rsp_err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_b2b: valid=%b rdata=%h err=%b psel=%b, need valid=%b rdata=%h err=0 psel=0",
                         rsp_valid, rsp_rdata, rsp_err, psel,
                         N'(1 << rsp_g), rsp_data);
            end
            rsp_pend = 1'b0;
        end
        g = ref_grant(req_valid);
        exp_rdy = (g < 0) ? '0 : N'(1 << g);
        n_chk++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b need %b (valid=%b)",
                     req_ready, exp_rdy, req_valid);
        end
        if (g < 0) return;
        w = req_write[g];
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        ptr_m = g;
        @(negedge clk);
        if (keep) begin
            req_write[g] = 1'($urandom);
            req_addr[g*AW +: AW] = AW'($urandom);
            req_wdata[g*DW +: DW] = $urandom;
        end else begin
            req_valid[g] = 1'b0;
        end
        #1;
        n_chk++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid} !==
            {1'b1, 1'b0, w, a, d, N'(0), N'(0)}) begin
            n_fail++;
            $display("FAIL setup: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rv=%b, need 1 0 %b %h %h 0 0",
                     psel, penable, pwrite, paddr, pwdata, req_ready,
                     rsp_valid, w, a, d);
        end
        for (int k = 0; k <= waits; k++) begin
            @(negedge clk);
            pready = (k == waits);
            prdata = (k == waits) ? rd : $urandom;
            #1;
            n_chk++;
            if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid} !==
                {1'b1, 1'b1, w, a, d, N'(0), N'(0)}) begin
                n_fail++;
                $display("FAIL access%0d: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rv=%b, need 1 1 %b %h %h 0 0",
                         k, psel, penable, pwrite, paddr, pwdata,
                         req_ready, rsp_valid, w, a, d);
            end
        end
        @(negedge clk);
        pready   = 1'b0;
        prdata   = $urandom;
        rsp_pend = 1'b1;
        rsp_g    = g;
        rsp_data = w ? '0 : rd;
    endtask

    // Completion cycle with no new request, then one idle cycle
    task automatic check_done();
        #1;
        if (rsp_pend) begin
            n_chk++;
            if (rsp_valid !== N'(1 << rsp_g) || rsp_rdata !== rsp_data ||
                rsp_err !== 1'b0 || psel !== 1'b0 || penable !== 1'b0 ||
                req_ready !== '0) begin
                n_fail++;
                $display("FAIL rsp: valid=%b rdata=%h err=%b psel=%b rdy=%b, need valid=%b rdata=%h err=0 psel=0 rdy=0",
                         rsp_valid, rsp_rdata, rsp_err, psel, req_ready,
                         N'(1 << rsp_g), rsp_data);
            end
            rsp_pend = 1'b0;
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== '0 || rsp_rdata !== rsp_data || psel !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_hold: valid=%b rdata=%h psel=%b, need valid=0 rdata=%h psel=0",
                     rsp_valid, rsp_rdata, psel, rsp_data);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b01;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;
        ptr_m     = N - 1;
        rsp_pend  = 1'b0;
        rsp_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid,
             rsp_rdata, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rv=%b rd=%h err=%b, need all 0",
                     psel, penable, pwrite, paddr, pwdata, req_ready,
                     rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        req_valid = '0;
        reset_n   = 1'b1;
    endtask

    task automatic test_write();
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[0 +: AW]  = 16'h0004;
        req_wdata[0 +: DW] = 32'h0000_00FF;
        xfer(0, 32'hDEAD_BEEF, 1'b0);
        check_done();
    endtask

    task automatic test_read();
        @(negedge clk);
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[AW +: AW] = 16'h0008;
        req_wdata[DW +: DW] = $urandom;
        xfer(0, 32'h0000_005A, 1'b0);
        check_done();
    endtask

    task automatic test_back_to_back();
        int exp_g;
        @(negedge clk);
        req_valid = 2'b11;
        req_write = 2'($urandom);
        req_addr  = {N*AW/32{$urandom}};
        req_wdata = {$urandom, $urandom};
        for (int t = 0; t < 6; t++) begin
            exp_g = t % 2;
            n_chk++;
            if (ref_grant(req_valid) !== exp_g) begin
                n_fail++;
                $display("FAIL rotate%0d: model grant %0d, need %0d",
                         t, ref_grant(req_valid), exp_g);
            end
            xfer(0, $urandom, 1'b1);
        end
        req_valid = '0;
        check_done();
    endtask

    task automatic test_wait_states();
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[0 +: AW]  = AW'($urandom);
        req_wdata[0 +: DW] = $urandom;
        xfer(3, $urandom, 1'b0);
        check_done();
        @(negedge clk);
        req_valid = 2'b10;
        req_write = 2'b00;
        xfer(3, $urandom, 1'b0);
        check_done();
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int t = 0; t < 30; t++) begin
            req_valid = 2'($urandom_range(1, 3));
            req_write = 2'($urandom);
            req_addr  = {N*AW/32{$urandom}};
            req_wdata = {$urandom, $urandom};
            xfer($urandom_range(0, 3), $urandom, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                req_valid = '0;
                check_done();
                @(negedge clk);
            end
        end
        req_valid = '0;
        check_done();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b00;
        xfer(0, $urandom, 1'b0);
        req_valid = '0;
        check_done();
        @(negedge clk);
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {N*AW/32{$urandom | 32'h0001_0001}};
        req_wdata = {$urandom | 32'h1, $urandom | 32'h1};
        #1;
        n_chk++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL rm_grant: req_ready=%b need 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b01;
        @(negedge clk);
        #1;
        n_chk++;
        if (psel !== 1'b1 || penable !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_access: sel=%b en=%b need 1 1", psel, penable);
        end
        @(negedge clk);
        reset_n = 1'b0;
        pready  = 1'b1;
        prdata  = $urandom;
        #1;
        n_chk++;
        if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid,
             rsp_rdata, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL rm_reset: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b rv=%b rd=%h err=%b, need all 0",
                     psel, penable, pwrite, paddr, pwdata, req_ready,
                     rsp_valid, rsp_rdata, rsp_err);
        end
        ptr_m    = N - 1;
        rsp_pend = 1'b0;
        rsp_data = '0;
        @(negedge clk);
        #1;
        n_chk++;
        if (rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL rm_norsp: rsp_valid=%b need 00", rsp_valid);
        end
        @(negedge clk);
        pready    = 1'b0;
        reset_n   = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        xfer(1, $urandom, 1'b0);
        req_valid = '0;
        check_done();
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        req_valid = 2'b01;
        req_write = 2'b00;
        #1;
        n_chk++;
        if (req_ready !== N'(1 << ref_grant(req_valid))) begin
            n_fail++;
            $display("FAIL to_grant: req_ready=%b", req_ready);
        end
        ptr_m = ref_grant(req_valid);
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk);
            pready = 1'b0;
            #1;
            n_chk++;
            if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== '0) begin
                n_fail++;
                $display("FAIL to_wait%0d: sel=%b en=%b rv=%b need 1 1 0",
                         k, psel, penable, rsp_valid);
            end
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (psel !== 1'b0 || penable !== 1'b0 ||
            rsp_valid !== N'(1 << ptr_m) || rsp_err !== 1'b1 ||
            rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL to_abort: sel=%b en=%b rv=%b err=%b rd=%h, need 0 0 %b 1 0",
                     psel, penable, rsp_valid, rsp_err, rsp_rdata,
                     N'(1 << ptr_m));
        end
        rsp_data = '0;
        @(negedge clk);
        req_valid = 2'b11;
        req_write = 2'b00;
        xfer(2, $urandom, 1'b0);
        req_valid = '0;
        check_done();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_wait_states();
        test_random();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
